// File: rtl/bridge_pkg.sv
// AHB2APB bridge shared types.
// State encoding and default bus widths.
package bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NSEL_DEF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_e;

  function automatic logic is_wr_setup(
    state_e s
  );
    return (s == ST_WRITE) ||
           (s == ST_WRITEP);
  endfunction

endpackage

// File: rtl/apb_controller_if.sv
// AHB-pipeline inputs and APB outputs of the bridge controller.
// master = the controller itself, slave = its environment.
interface apb_controller_if
  import bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSEL   = NSEL_DEF
);

  logic              valid;
  logic              hwrite;
  logic              hwrite_reg;
  logic [ADDR_W-1:0] haddr;
  logic [ADDR_W-1:0] haddr_1;
  logic [ADDR_W-1:0] haddr_2;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hwdata_1;
  logic [NSEL-1:0]   temp_selx;
  logic [NSEL-1:0]   pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              hreadyout;

  modport master (
    input  valid,
    input  hwrite,
    input  hwrite_reg,
    input  haddr,
    input  haddr_1,
    input  haddr_2,
    input  hwdata,
    input  hwdata_1,
    input  temp_selx,
    output pselx,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    output hreadyout
  );

  modport slave (
    output valid,
    output hwrite,
    output hwrite_reg,
    output haddr,
    output haddr_1,
    output haddr_2,
    output hwdata,
    output hwdata_1,
    output temp_selx,
    input  pselx,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    input  hreadyout
  );

endinterface

// File: rtl/apb_controller.sv
// APB-side FSM of the AHB2APB bridge.
// One SETUP+ENABLE APB transfer per AHB transfer.
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSEL   = NSEL_DEF
)(
  input  logic hclk,
  input  logic hresetn,
  apb_controller_if.master bus
);

  state_e state_q, state_d;

  logic [NSEL-1:0]   pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              hready_q, hready_d;

  // Next-state decode.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid && bus.hwrite)
          state_d = ST_WWAIT;
        else if (bus.valid)
          state_d = ST_READ;
        else
          state_d = ST_IDLE;
      end
      ST_WWAIT:
        state_d = bus.valid ? ST_WRITEP
                            : ST_WRITE;
      ST_READ:
        state_d = ST_RENABLE;
      ST_WRITE:
        state_d = bus.valid ? ST_WENABLEP
                            : ST_WENABLE;
      ST_WRITEP:
        state_d = ST_WENABLEP;
      ST_RENABLE, ST_WENABLE: begin
        if (bus.valid && !bus.hwrite)
          state_d = ST_READ;
        else if (bus.valid)
          state_d = ST_WWAIT;
        else
          state_d = ST_IDLE;
      end
      ST_WENABLEP: begin
        if (!bus.hwrite_reg)
          state_d = ST_READ;
        else if (bus.valid)
          state_d = ST_WRITEP;
        else
          state_d = ST_WRITE;
      end
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    pselx_d   = pselx_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    hready_d  = 1'b1;
    if (state_d == ST_READ) begin
      pselx_d   = bus.temp_selx;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = bus.haddr;
      hready_d  = 1'b0;
    end else if (is_wr_setup(state_d)) begin
      pselx_d   = bus.temp_selx;
      penable_d = 1'b0;
      pwrite_d  = 1'b1;
      hready_d  = (state_d != ST_WRITEP);
      // Pipelined write: AHB has moved on,
      // so take the older address/data copies.
      if (state_q == ST_WENABLEP) begin
        paddr_d  = bus.haddr_2;
        pwdata_d = bus.hwdata_1;
      end else begin
        paddr_d  = bus.haddr_1;
        pwdata_d = bus.hwdata;
      end
    end else if (state_d == ST_RENABLE ||
                 state_d == ST_WENABLE ||
                 state_d == ST_WENABLEP) begin
      penable_d = 1'b1;
    end else begin
      pselx_d   = '0;
      penable_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Registered APB outputs and hreadyout.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hready_q  <= 1'b1;
    end else begin
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      hready_q  <= hready_d;
    end
  end

  assign bus.pselx     = pselx_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.hreadyout = hready_q;

endmodule

// File: tb/tb_apb_controller.sv
// Scoreboard bench for apb_controller.
// Directed AHB-side vectors, per-cycle APB expectations.
module tb_apb_controller;
  import bridge_pkg::*;

  typedef struct {
    int          cyc;
    string       nm;
    logic [69:0] v;
  } exp_t;

  exp_t sb[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   nvec  = 0;
  int   nmis  = 0;

  apb_controller_if bus ();

  apb_controller dut (
    .hclk    (clk),
    .hresetn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Upstream slave-interface pipeline model.
  always @(posedge clk) begin
    cyc            <= cyc + 1;
    bus.hwrite_reg <= bus.hwrite;
    bus.haddr_1    <= bus.haddr;
    bus.haddr_2    <= bus.haddr_1;
    bus.hwdata_1   <= bus.hwdata;
  end

  function automatic logic [69:0] pk(
    logic [2:0]  s,
    logic        en,
    logic        w,
    logic [31:0] a,
    logic [31:0] d,
    logic        hr
  );
    return {s, en, w, a, d, hr};
  endfunction

  function automatic logic [69:0] act();
    return {bus.pselx, bus.penable,
            bus.pwrite, bus.paddr,
            bus.pwdata, bus.hreadyout};
  endfunction

  task automatic cmp(
    string       nm,
    logic [69:0] a,
    logic [69:0] e
  );
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, a, e);
    end
  endtask

  task automatic ex(
    int          dc,
    string       nm,
    logic [2:0]  s,
    logic        en,
    logic        w,
    logic [31:0] a,
    logic [31:0] d,
    logic        hr
  );
    exp_t e;
    e.cyc = cyc + dc;
    e.nm  = nm;
    e.v   = pk(s, en, w, a, d, hr);
    sb.push_back(e);
  endtask

  task automatic drv(
    logic        v,
    logic        w,
    logic [31:0] a,
    logic [31:0] d,
    logic [2:0]  s
  );
    bus.valid     = v;
    bus.hwrite    = w;
    bus.haddr     = a;
    bus.hwdata    = d;
    bus.temp_selx = s;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop the expectation due this cycle,
  // otherwise the bus must be quiet.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      nvec++;
      nmis++;
      $display("FAIL %s missed: due cyc=%0d now=%0d",
               sb[0].nm, sb[0].cyc, cyc);
      sb.delete(0);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      cmp(sb[0].nm, act(), sb[0].v);
      sb.delete(0);
    end else begin
      cmp("quiet",
          {64'd0, bus.pselx, bus.penable,
           bus.pwrite & 1'b0, bus.hreadyout},
          {64'd0, 3'b000, 1'b0, 1'b0, 1'b1});
    end
  end

  localparam logic [31:0] R  = 32'h8000_0004;
  localparam logic [31:0] W  = 32'h8400_0010;
  localparam logic [31:0] D  = 32'h1234_5678;
  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h8000_0004;
  localparam logic [31:0] D0 = 32'hA5A5_A5A5;
  localparam logic [31:0] D1 = 32'h5A5A_5A5A;
  localparam logic [31:0] A8 = 32'h8000_0008;
  localparam logic [31:0] AC = 32'h8000_000C;
  localparam logic [31:0] DW = 32'hCAFE_F00D;
  localparam logic [31:0] B0 = 32'h8000_0020;
  localparam logic [31:0] B1 = 32'h8800_0024;
  localparam logic [31:0] F0 = 32'h8000_0030;
  localparam logic [31:0] F1 = 32'h8000_0034;
  localparam logic [31:0] DF = 32'h0BAD_BEEF;
  localparam logic [31:0] G  = 32'h8000_0040;

  initial begin
    bus.valid     = 1'b0;
    bus.hwrite    = 1'b0;
    bus.haddr     = '0;
    bus.hwdata    = '0;
    bus.temp_selx = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_init", act(),
        pk(3'b000, 0, 0, 0, 0, 1));
    rst_n = 1'b1;
    repeat (2) drv(0, 0, 0, 0, 3'b000);

    // Single read
    ex(1, "rd_read",    3'b001, 0, 0, R, 0, 0);
    ex(2, "rd_renable", 3'b001, 1, 0, R, 0, 1);
    ex(3, "rd_idle",    3'b000, 0, 0, R, 0, 1);
    drv(1, 0, R, 0, 3'b001);
    repeat (4) drv(0, 0, R, 0, 3'b001);

    // Single write
    ex(1, "wr_wwait",   3'b000, 0, 0, R, 0, 1);
    ex(2, "wr_write",   3'b010, 0, 1, W, D, 1);
    ex(3, "wr_wenable", 3'b010, 1, 1, W, D, 1);
    ex(4, "wr_idle",    3'b000, 0, 1, W, D, 1);
    drv(1, 1, W, 0, 3'b010);
    drv(0, 1, W, D, 3'b010);
    repeat (4) drv(0, 0, W, 0, 3'b010);

    // Back-to-back writes
    ex(1, "bb_wwait",    3'b000, 0, 1, W,  D,  1);
    ex(2, "bb_writep",   3'b100, 0, 1, A0, D0, 0);
    ex(3, "bb_wenablep", 3'b100, 1, 1, A0, D0, 1);
    ex(4, "bb_write",    3'b100, 0, 1, A1, D1, 1);
    ex(5, "bb_wenable",  3'b100, 1, 1, A1, D1, 1);
    ex(6, "bb_idle",     3'b000, 0, 1, A1, D1, 1);
    drv(1, 1, A0, 0,  3'b100);
    drv(1, 1, A1, D0, 3'b100);
    drv(0, 1, A1, D1, 3'b100);
    repeat (5) drv(0, 0, A1, D1, 3'b100);

    // Write followed by read
    ex(1, "wr_rd_wwait",    3'b000, 0, 1, A1, D1, 1);
    ex(2, "wr_rd_writep",   3'b001, 0, 1, A8, DW, 0);
    ex(3, "wr_rd_wenablep", 3'b001, 1, 1, A8, DW, 1);
    ex(4, "wr_rd_read",     3'b001, 0, 0, AC, DW, 0);
    ex(5, "wr_rd_renable",  3'b001, 1, 0, AC, DW, 1);
    ex(6, "wr_rd_idle",     3'b000, 0, 0, AC, DW, 1);
    drv(1, 1, A8, 0,  3'b001);
    drv(1, 0, AC, DW, 3'b001);
    drv(1, 0, AC, DW, 3'b001);
    repeat (5) drv(0, 0, AC, 0, 3'b001);

    // Back-to-back reads to different slaves
    ex(1, "rr_read0",   3'b010, 0, 0, B0, DW, 0);
    ex(2, "rr_enable0", 3'b010, 1, 0, B0, DW, 1);
    ex(3, "rr_read1",   3'b100, 0, 0, B1, DW, 0);
    ex(4, "rr_enable1", 3'b100, 1, 0, B1, DW, 1);
    ex(5, "rr_idle",    3'b000, 0, 0, B1, DW, 1);
    drv(1, 0, B0, 0, 3'b010);
    drv(0, 0, B0, 0, 3'b010);
    drv(1, 0, B1, 0, 3'b100);
    repeat (4) drv(0, 0, B1, 0, 3'b100);

    // Read, write, then reset inside WENABLE
    ex(1, "rw_read",    3'b001, 0, 0, F0, DW, 0);
    ex(2, "rw_renable", 3'b001, 1, 0, F0, DW, 1);
    ex(3, "rw_wwait",   3'b000, 0, 0, F0, DW, 1);
    ex(4, "rw_write",   3'b001, 0, 1, F1, DF, 1);
    ex(5, "rw_wenable", 3'b001, 1, 1, F1, DF, 1);
    drv(1, 0, F0, 0,  3'b001);
    drv(0, 0, F0, 0,  3'b001);
    drv(1, 1, F1, 0,  3'b001);
    drv(0, 1, F1, DF, 3'b001);
    drv(0, 0, F1, 0,  3'b001);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("async_reset", act(),
        pk(3'b000, 0, 0, 0, 0, 1));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) drv(0, 0, 0, 0, 3'b000);

    // Normal read after reset recovery
    ex(1, "rec_read",    3'b010, 0, 0, G, 0, 0);
    ex(2, "rec_renable", 3'b010, 1, 0, G, 0, 1);
    ex(3, "rec_idle",    3'b000, 0, 0, G, 0, 1);
    drv(1, 0, G, 0, 3'b010);
    repeat (5) drv(0, 0, G, 0, 3'b010);

    if (sb.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL leftover: got=%0d want=0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
